id_ex_hazard_reg: RTL and testbench

//  ID/EX pipeline register with integrated hazard control for the 5-stage MIPS pipeline.
//  - Captures decoded ID fields and presents EX_rs, EX_rt, EX_WeSel and EX controls to the EX stage and forwarding unit.
//  - Detects load-use and HI/LO (mult/div busy) hazards: stalls PC and IF/ID, and injects a bubble into EX.
//  - Tracks occupancy of the multi-cycle MULT/DIV unit.

---
 rtl/id_ex_hazard_reg.sv | 159 +++++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_hazard_reg
//  Purpose  : ID/EX pipeline register with load-use / HI-LO hazard stall,
//             bubble injection and MULT/DIV occupancy tracking.
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_hazard_reg #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4,
    parameter int MD_LAT  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         ID_rs,
    input  logic [4:0]         ID_rt,
    input  logic               ID_UsesRs,
    input  logic               ID_UsesRt,
    input  logic [4:0]         ID_WeSel,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemToReg,
    input  logic               ID_ALUSrc,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [DATA_W-1:0]  ID_RegData1,
    input  logic [DATA_W-1:0]  ID_RegData2,
    input  logic [DATA_W-1:0]  ID_Imm,
    input  logic [DATA_W-1:0]  ID_PC,
    input  logic               ID_MDStart,
    input  logic               ID_HiLoRead,
    input  logic               EX_Flush,
    output logic [4:0]         EX_rs,
    output logic [4:0]         EX_rt,
    output logic [4:0]         EX_WeSel,
    output logic               EX_RegWrite,
    output logic               EX_MemRead,
    output logic               EX_MemWrite,
    output logic               EX_MemToReg,
    output logic               EX_ALUSrc,
    output logic               EX_MDStart,
    output logic [ALUOP_W-1:0] EX_ALUOp,
    output logic [DATA_W-1:0]  EX_RegData1,
    output logic [DATA_W-1:0]  EX_RegData2,
    output logic [DATA_W-1:0]  EX_Imm,
    output logic [DATA_W-1:0]  EX_PC,
    output logic               EX_Valid,
    output logic               Stall,
    output logic               MD_Busy
);

    localparam int                CNT_W    = $clog2(MD_LAT + 1);
    localparam logic [CNT_W-1:0]  C_MD_LAT = CNT_W'(MD_LAT);

    logic [4:0]         r_rs, r_rt, r_wesel;
    logic               r_regwrite, r_memread, r_memwrite, r_memtoreg;
    logic               r_alusrc, r_mdstart, r_valid;
    logic [ALUOP_W-1:0] r_aluop;
    logic [DATA_W-1:0]  r_data1, r_data2, r_imm, r_pc;
    logic [CNT_W-1:0]   r_md_cnt;

    logic w_load_use;
    logic w_md_haz;
    logic w_stall;
    logic w_bubble;
    logic w_md_busy;

    assign w_md_busy  = (r_md_cnt != '0);
    assign w_load_use = r_valid & r_memread & (r_wesel != 5'd0) &
                        ((ID_UsesRs & (ID_rs == r_wesel)) |
                         (ID_UsesRt & (ID_rt == r_wesel)));
    assign w_md_haz   = w_md_busy & (ID_HiLoRead | ID_MDStart);
    // A flushed ID instruction is discarded, so it must never be held.
    assign w_stall    = ~EX_Flush & (w_load_use | w_md_haz);
    assign w_bubble   = EX_Flush | w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs       <= '0;
            r_rt       <= '0;
            r_wesel    <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrc   <= 1'b0;
            r_mdstart  <= 1'b0;
            r_aluop    <= '0;
            r_data1    <= '0;
            r_data2    <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_valid    <= 1'b0;
        end else if (w_bubble) begin
            r_rs       <= '0;
            r_rt       <= '0;
            r_wesel    <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alusrc   <= 1'b0;
            r_mdstart  <= 1'b0;
            r_aluop    <= '0;
            r_data1    <= '0;
            r_data2    <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_rs       <= ID_rs;
            r_rt       <= ID_rt;
            r_wesel    <= ID_WeSel;
            r_regwrite <= ID_RegWrite;
            r_memread  <= ID_MemRead;
            r_memwrite <= ID_MemWrite;
            r_memtoreg <= ID_MemToReg;
            r_alusrc   <= ID_ALUSrc;
            r_mdstart  <= ID_MDStart;
            r_aluop    <= ID_ALUOp;
            r_data1    <= ID_RegData1;
            r_data2    <= ID_RegData2;
            r_imm      <= ID_Imm;
            r_pc       <= ID_PC;
            r_valid    <= 1'b1;
        end
    end

    // Counter loads only when the MULT/DIV is actually captured into EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_md_cnt <= '0;
        end else if (!w_bubble && ID_MDStart) begin
            r_md_cnt <= C_MD_LAT;
        end else if (w_md_busy) begin
            r_md_cnt <= r_md_cnt - CNT_W'(1);
        end
    end

    assign EX_rs       = r_rs;
    assign EX_rt       = r_rt;
    assign EX_WeSel    = r_wesel;
    assign EX_RegWrite = r_regwrite;
    assign EX_MemRead  = r_memread;
    assign EX_MemWrite = r_memwrite;
    assign EX_MemToReg = r_memtoreg;
    assign EX_ALUSrc   = r_alusrc;
    assign EX_MDStart  = r_mdstart;
    assign EX_ALUOp    = r_aluop;
    assign EX_RegData1 = r_data1;
    assign EX_RegData2 = r_data2;
    assign EX_Imm      = r_imm;
    assign EX_PC       = r_pc;
    assign EX_Valid    = r_valid;
    assign Stall       = w_stall;
    assign MD_Busy     = w_md_busy;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_hazard_reg
//  Purpose  : Directed vector bench for id_ex_hazard_reg (MD_LAT = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_hazard_reg;

    localparam int DATA_W  = 32;
    localparam int ALUOP_W = 4;
    localparam int MD_LAT  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [4:0]         ID_rs, ID_rt, ID_WeSel;
    logic               ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead;
    logic               ID_MemWrite, ID_MemToReg, ID_ALUSrc;
    logic [ALUOP_W-1:0] ID_ALUOp;
    logic [DATA_W-1:0]  ID_RegData1, ID_RegData2, ID_Imm, ID_PC;
    logic               ID_MDStart, ID_HiLoRead, EX_Flush;
    logic [4:0]         EX_rs, EX_rt, EX_WeSel;
    logic               EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg;
    logic               EX_ALUSrc, EX_MDStart, EX_Valid, Stall, MD_Busy;
    logic [ALUOP_W-1:0] EX_ALUOp;
    logic [DATA_W-1:0]  EX_RegData1, EX_RegData2, EX_Imm, EX_PC;

    int n_checks = 0;
    int n_err    = 0;

    id_ex_hazard_reg #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_WeSel(ID_WeSel), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc),
        .ID_ALUOp(ID_ALUOp), .ID_RegData1(ID_RegData1), .ID_RegData2(ID_RegData2),
        .ID_Imm(ID_Imm), .ID_PC(ID_PC), .ID_MDStart(ID_MDStart), .ID_HiLoRead(ID_HiLoRead),
        .EX_Flush(EX_Flush),
        .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_WeSel(EX_WeSel), .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_MemToReg(EX_MemToReg),
        .EX_ALUSrc(EX_ALUSrc), .EX_MDStart(EX_MDStart), .EX_ALUOp(EX_ALUOp),
        .EX_RegData1(EX_RegData1), .EX_RegData2(EX_RegData2), .EX_Imm(EX_Imm),
        .EX_PC(EX_PC), .EX_Valid(EX_Valid), .Stall(Stall), .MD_Busy(MD_Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] we;
        logic       rw, mr, fl;
        logic       e_stall, e_valid;
        logic [4:0] e_rs, e_we;
        logic       e_rw, e_mr;
    } vec_t;

    vec_t tv [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        ID_rs = 0; ID_rt = 0; ID_UsesRs = 0; ID_UsesRt = 0; ID_WeSel = 0;
        ID_RegWrite = 0; ID_MemRead = 0; ID_MemWrite = 0; ID_MemToReg = 0;
        ID_ALUSrc = 0; ID_ALUOp = 0; ID_RegData1 = 0; ID_RegData2 = 0;
        ID_Imm = 0; ID_PC = 0; ID_MDStart = 0; ID_HiLoRead = 0; EX_Flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_data"}, {EX_RegData1 | EX_RegData2 | EX_Imm | EX_PC, 32'd0}, 64'd0);
        check({name, "_ctl"}, {35'd0, EX_rs, EX_rt, EX_WeSel, EX_ALUOp, EX_RegWrite, EX_MemRead,
              EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_MDStart, EX_Valid, Stall, MD_Busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [63:0] e_oth;
        int          n;

        tv[0]  = '{1, 8, 1, 0, 8, 1, 1, 0,   0, 1, 1, 8, 1, 1};
        tv[1]  = '{8, 2, 1, 1, 3, 1, 0, 0,   1, 0, 0, 0, 0, 0};
        tv[2]  = '{8, 2, 1, 1, 3, 1, 0, 0,   0, 1, 8, 3, 1, 0};
        tv[3]  = '{4, 0, 1, 0, 0, 1, 1, 0,   0, 1, 4, 0, 1, 1};
        tv[4]  = '{0, 5, 1, 1, 6, 1, 0, 0,   0, 1, 0, 6, 1, 0};
        tv[5]  = '{2, 0, 1, 0, 9, 1, 1, 0,   0, 1, 2, 9, 1, 1};
        tv[6]  = '{3, 9, 1, 0, 10, 1, 0, 0,  0, 1, 3, 10, 1, 0};
        tv[7]  = '{3, 0, 1, 0, 12, 1, 1, 0,  0, 1, 3, 12, 1, 1};
        tv[8]  = '{1, 12, 1, 1, 13, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[9]  = '{12, 0, 1, 0, 14, 1, 0, 0, 0, 1, 12, 14, 1, 0};
        tv[10] = '{1, 0, 1, 0, 15, 1, 1, 0,  0, 1, 1, 15, 1, 1};
        tv[11] = '{2, 15, 1, 1, 16, 1, 0, 0, 1, 0, 0, 0, 0, 0};
        tv[12] = '{2, 15, 1, 1, 16, 1, 0, 0, 0, 1, 2, 16, 1, 0};

        idle();
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Vector table: Stall sampled before the edge, EX fields after it.
        for (int i = 0; i < 13; i++) begin
            d = 32'hA000_0000 + 32'(i) * 32'h111;
            ID_rs = tv[i].rs; ID_rt = tv[i].rt; ID_UsesRs = tv[i].urs; ID_UsesRt = tv[i].urt;
            ID_WeSel = tv[i].we; ID_RegWrite = tv[i].rw; ID_MemRead = tv[i].mr;
            ID_MemToReg = tv[i].mr; ID_ALUSrc = ~tv[i].urt; ID_MemWrite = d[0] ^ 1'b1;
            ID_ALUOp = 4'(i); ID_RegData1 = d; ID_RegData2 = ~d; ID_Imm = d + 1;
            ID_PC = d + 4; EX_Flush = tv[i].fl;
            #1;
            check($sformatf("v%0d_stall", i), {63'd0, Stall}, {63'd0, tv[i].e_stall});
            tick();
            e_oth = tv[i].e_valid ? {19'd0, tv[i].rt, 4'(i), ~d, d[0] ^ 1'b1, tv[i].mr, ~tv[i].urt, 1'b0}
                                  : 64'd0;
            check($sformatf("v%0d_valid", i), {63'd0, EX_Valid}, {63'd0, tv[i].e_valid});
            check($sformatf("v%0d_idx", i), {54'd0, EX_rs, EX_WeSel}, {54'd0, tv[i].e_rs, tv[i].e_we});
            check($sformatf("v%0d_ctl", i), {62'd0, EX_RegWrite, EX_MemRead}, {62'd0, tv[i].e_rw, tv[i].e_mr});
            check($sformatf("v%0d_data1", i), {32'd0, EX_RegData1}, tv[i].e_valid ? {32'd0, d} : 64'd0);
            check($sformatf("v%0d_immpc", i), {EX_Imm, EX_PC}, tv[i].e_valid ? {d + 32'd1, d + 32'd4} : 64'd0);
            check($sformatf("v%0d_other", i),
                  {19'd0, EX_rt, EX_ALUOp, EX_RegData2, EX_MemWrite, EX_MemToReg, EX_ALUSrc, EX_MDStart},
                  e_oth);
        end

        // MULT followed by MFLO: MFLO held for MD_LAT cycles.
        idle();
        ID_rs = 4; ID_rt = 5; ID_UsesRs = 1; ID_UsesRt = 1; ID_MDStart = 1;
        #1;
        check("mult_stall", {63'd0, Stall}, 64'd0);
        tick();
        check("mult_ex", {62'd0, EX_MDStart, MD_Busy}, 64'd3);
        idle();
        ID_HiLoRead = 1; ID_WeSel = 7; ID_RegWrite = 1;
        for (int i = 0; i < MD_LAT; i++) begin
            #1;
            check($sformatf("mflo_hold%0d", i), {62'd0, MD_Busy, Stall}, 64'd3);
            tick();
            check($sformatf("mflo_bub%0d", i), {63'd0, EX_Valid}, 64'd0);
        end
        check("mflo_free", {62'd0, MD_Busy, Stall}, 64'd0);
        tick();
        check("mflo_ex", {58'd0, EX_Valid, EX_WeSel}, {58'd0, 1'b1, 5'd7});

        // Back-to-back DIV: second held, counter reloads on its capture.
        idle();
        ID_MDStart = 1; ID_rs = 3;
        tick();
        ID_rs = 6;
        for (int i = 0; i < MD_LAT; i++) begin
            check($sformatf("div2_hold%0d", i), {63'd0, Stall}, 64'd1);
            tick();
        end
        check("div2_free", {62'd0, MD_Busy, Stall}, 64'd0);
        tick();
        idle();
        check("div2_ex", {57'd0, EX_MDStart, MD_Busy, EX_rs}, {57'd0, 1'b1, 1'b1, 5'd6});
        n = 0;
        while (MD_Busy && n < 10) begin
            n++;
            tick();
        end
        check("div2_busy_len", 64'(n), 64'(MD_LAT));

        // Asynchronous reset mid-count with a stall pending.
        ID_MDStart = 1; ID_RegWrite = 1; ID_WeSel = 2;
        tick();
        idle();
        ID_HiLoRead = 1;
        #1;
        check("prerst", {61'd0, EX_RegWrite, MD_Busy, Stall}, 64'd7);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst", {62'd0, MD_Busy, Stall}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
